line_fetch_sequencer: RTL

- Draw-domain stage that sits directly upstream of the tile BRAM and pixel doubler.
- On each synchronized line pulse, it latches the scanline and scroll registers, then streams one tile-word request per accepted cycle: tile_y/tile_x/tile_row/tile_col plus the line-buffer x position and buffer select.
- It replaces the free-running tile counter with a bounded, scrollable, back-pressurable fetch sequence per line, and reports busy/done for later arbitration with sprite fetch.

---
 rtl/line_fetch_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/line_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : line_fetch_sequencer
// Purpose  : Draw-domain tile-word fetch sequencer. Each line pulse latches
//            the scanline and scroll values. The block then issues WORDS
//            tile-word requests. Each request advances only when it is
//            accepted (valid && ready).
// Ports    : clk_draw, rst_draw (async, active-low)
//            line, sy, scroll_x, scroll_y   - line start and its parameters
//            ready                          - downstream accept
//            valid, tile_y, tile_x, tile_row, tile_col, lb_x, bufsel, first
//                                           - registered request outputs
//            busy, done                     - sequence status
// Revision : 1.0 - initial release
// ============================================================================
module line_fetch_sequencer #(
    parameter int CORDW = 11,
    parameter int WORDS = 81,
    parameter int LBW   = 12
) (
    input  logic             clk_draw,
    input  logic             rst_draw,
    input  logic             line,
    input  logic [CORDW-1:0] sy,
    input  logic [9:0]       scroll_x,
    input  logic [8:0]       scroll_y,
    input  logic             ready,
    output logic             valid,
    output logic [4:0]       tile_y,
    output logic [4:0]       tile_x,
    output logic [2:0]       tile_row,
    output logic             tile_col,
    output logic [LBW-1:0]   lb_x,
    output logic             bufsel,
    output logic             first,
    output logic             busy,
    output logic             done
);

    localparam int CNTW = $clog2(WORDS);
    localparam logic [CNTW-1:0] C_LAST_WORD = CNTW'(WORDS - 1);
    localparam logic [LBW-1:0]  C_WORD_PIX  = LBW'(8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [CNTW-1:0] count_q,  count_d;
    // Tile-map word index. Only the low 6 bits of the start word matter,
    // because the map row holds 64 words.
    logic [5:0]      idx_q,    idx_d;
    logic [8:0]      eff_y_q,  eff_y_d;
    logic [LBW-1:0]  lb_x_q,   lb_x_d;
    logic            bufsel_q, bufsel_d;
    logic            first_q,  first_d;
    logic            valid_q,  valid_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic            w_xfer;

    // Only sy[8:0] and scroll_x[8:0] take part in the fetch arithmetic.
    logic            w_unused;
    assign w_unused = ^{sy[CORDW-1:9], scroll_x[9]};

    assign w_xfer = valid_q && ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        eff_y_d  = eff_y_q;
        lb_x_d   = lb_x_q;
        bufsel_d = bufsel_q;
        first_d  = first_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;

        if (line) begin
            // A line pulse always (re)starts the sequence. It wins over a
            // transfer in the same cycle, so an aborted line never reaches
            // DONE.
            state_d  = S_FETCH;
            count_d  = '0;
            idx_d    = scroll_x[8:3];
            eff_y_d  = sy[8:0] + scroll_y;
            // Fine scroll shifts the first word left of column 0. The
            // negative start is intentional; downstream masks the writes.
            lb_x_d   = '0 - {{(LBW-3){1'b0}}, scroll_x[2:0]};
            bufsel_d = sy[0];
            first_d  = 1'b1;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                S_FETCH: begin
                    if (w_xfer) begin
                        if (count_q == C_LAST_WORD) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            first_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                            idx_d   = idx_q + 1'b1;
                            lb_x_d  = lb_x_q + C_WORD_PIX;
                            first_d = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    first_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_draw or negedge rst_draw) begin
        if (!rst_draw) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            eff_y_q  <= '0;
            lb_x_q   <= '0;
            bufsel_q <= 1'b0;
            first_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            eff_y_q  <= eff_y_d;
            lb_x_q   <= lb_x_d;
            bufsel_q <= bufsel_d;
            first_q  <= first_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Tile map is 32x32 tiles of 8x8 texels, doubled to 16x16 screen pixels.
    // Each texel row therefore covers two screen lines, and each tile row
    // splits into two words.
    assign valid    = valid_q;
    assign tile_y   = eff_y_q[8:4];
    assign tile_row = eff_y_q[3:1];
    assign tile_x   = idx_q[5:1];
    assign tile_col = idx_q[0];
    assign lb_x     = lb_x_q;
    assign bufsel   = bufsel_q;
    assign first    = first_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire
